i2c_reg_ctrl: RTL and testbench

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_reg_ctrl.sv | 139 +++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: I2C write-only register slave with a shared read port.
//   A byte-level I2C front end (START/STOP/byte pulses) addresses the device,
//   loads a register pointer and writes data bytes into a single-ported
//   register file. A PWM engine reads the same file through a request/grant
//   port. I2C writes win a collision, and the read is granted one cycle later.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   addr_i[5:0]            device address pins (replace BASE_ADDR[5:0])
//   bus_start_i/stop_i     START (or repeated START) / STOP pulses
//   byte_valid_i, byte_i   received byte strobe and data
//   ack_o                  registered ACK(1)/NACK(0) for the last byte
//   rd_req_i, rd_addr_i    read request (held until granted) and address
//   rd_gnt_o, rd_data_o    one-cycle grant with read data
//   mode1_o                live copy of register 0x00 (MODE1)
// Build option: define I2C_REG_CTRL_AUTOINC_EN to enable pointer
//   auto-increment while MODE1[5]=1.
module i2c_reg_ctrl #(
  parameter logic [6:0]  BASE_ADDR = 7'h40,
  parameter int unsigned NUM_REGS  = 70
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] addr_i,
  input  logic       bus_start_i,
  input  logic       bus_stop_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       ack_o,
  input  logic       rd_req_i,
  input  logic [7:0] rd_addr_i,
  output logic       rd_gnt_o,
  output logic [7:0] rd_data_o,
  output logic [7:0] mode1_o
);

  localparam int unsigned      PTR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REGS - 1);
  localparam logic [7:0]       MODE1_RST = 8'h11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PTR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];

  logic byte_ok;
  logic wr_en;
  logic rd_acc;
  logic addr_match;
  logic ptr_ok;
  logic rd_ok;
  logic autoinc;

  // START/STOP take precedence over a coincident byte, which is dropped.
  assign byte_ok    = byte_valid_i & ~bus_start_i & ~bus_stop_i;
  assign wr_en      = byte_ok & (state == S_DATA);
  assign rd_acc     = rd_req_i & ~wr_en;
  assign addr_match = (byte_i[7:1] == {BASE_ADDR[6], addr_i});
  assign ptr_ok     = 32'(byte_i) < NUM_REGS;
  assign rd_ok      = 32'(rd_addr_i) < NUM_REGS;
  assign mode1_o    = regs[0];

`ifdef I2C_REG_CTRL_AUTOINC_EN
  assign autoinc = regs[0][5];
`else
  assign autoinc = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      ptr   <= '0;
      ack_o <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? MODE1_RST : '0;
      end
    end else if (bus_start_i) begin
      state <= S_ADDR;
      ack_o <= 1'b0;
    end else if (bus_stop_i) begin
      state <= S_IDLE;
      ack_o <= 1'b0;
    end else if (byte_valid_i) begin
      case (state)
        S_ADDR: begin
          if (addr_match && !byte_i[0]) begin
            ack_o <= 1'b1;
            state <= S_PTR;
          end else begin
            ack_o <= 1'b0;
            state <= S_IGNORE;
          end
        end
        S_PTR: begin
          if (ptr_ok) begin
            ptr   <= byte_i[PTR_W-1:0];
            ack_o <= 1'b1;
            state <= S_DATA;
          end else begin
            ack_o <= 1'b0;
            state <= S_IGNORE;
          end
        end
        S_DATA: begin
          regs[ptr] <= byte_i;
          ack_o     <= 1'b1;
          // Increment decision uses MODE1 as it stood before this write.
          if (autoinc) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
          end
        end
        default: begin
          ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Read port: a read blocked by a write simply stays requested and is
  // accepted in the following (write-free) cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_gnt_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_gnt_o <= rd_acc;
      if (rd_acc) begin
        rd_data_o <= rd_ok ? regs[rd_addr_i[PTR_W-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: scoreboard bench for i2c_reg_ctrl. Expected ACKs and read
// data are queued when stimulus is driven and compared when the DUT responds.
module tb_i2c_reg_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] addr_i = '0;
  logic       bus_start_i = 1'b0;
  logic       bus_stop_i = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = '0;
  logic       ack_o;
  logic       rd_req_i = 1'b0;
  logic [7:0] rd_addr_i = '0;
  logic       rd_gnt_o;
  logic [7:0] rd_data_o;
  logic [7:0] mode1_o;

  int checks = 0;
  int errors = 0;

  logic       ack_q [$];
  logic [7:0] rd_q  [$];

  i2c_reg_ctrl #(
    .BASE_ADDR (7'h40),
    .NUM_REGS  (70)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .bus_start_i  (bus_start_i),
    .bus_stop_i   (bus_stop_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .ack_o        (ack_o),
    .rd_req_i     (rd_req_i),
    .rd_addr_i    (rd_addr_i),
    .rd_gnt_o     (rd_gnt_o),
    .rd_data_o    (rd_data_o),
    .mode1_o      (mode1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    @(negedge clk_i); bus_start_i = 1'b1;
    @(negedge clk_i); bus_start_i = 1'b0;
  endtask

  task automatic bus_stop();
    @(negedge clk_i); bus_stop_i = 1'b1;
    @(negedge clk_i); bus_stop_i = 1'b0;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    ack_q.push_back(exp_ack);
    @(negedge clk_i); byte_i = b; byte_valid_i = 1'b1;
    @(posedge clk_i); #1;
    check(tag, ack_o, ack_q.pop_front());
    @(negedge clk_i); byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    int lat;
    logic got;
    rd_q.push_back(exp);
    lat = 0;
    got = 1'b0;
    @(negedge clk_i); rd_addr_i = a; rd_req_i = 1'b1;
    for (int i = 1; i <= 4 && !got; i++) begin
      @(posedge clk_i); #1;
      if (rd_gnt_o) begin
        got = 1'b1;
        lat = i;
      end
    end
    rd_req_i = 1'b0;
    check({tag, "_gnt"}, got, 1);
    check({tag, "_lat"}, lat, 1);
    check(tag, rd_data_o, rd_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_gnt", rd_gnt_o, 0);
    check("rst_rdata", rd_data_o, 8'h00);
    check("rst_mode1", mode1_o, 8'h11);
    @(negedge clk_i); rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Basic write: device 0x40, ptr 6, data 0xAB
    addr_i = 6'h00;
    bus_start();
    send_byte("w1_addr", 8'h80, 1'b1);
    send_byte("w1_ptr", 8'h06, 1'b1);
    send_byte("w1_data", 8'hAB, 1'b1);
    bus_stop();
    check("stop_clr_ack", ack_o, 0);
    rd("rd6", 8'h06, 8'hAB);

    // Address mismatch: all bytes NACKed, no side effects
    bus_start();
    send_byte("mm_addr", 8'h82, 1'b0);
    send_byte("mm_b1", 8'h06, 1'b0);
    send_byte("mm_b2", 8'hCD, 1'b0);
    bus_stop();
    rd("mm_rd6", 8'h06, 8'hAB);

    // Pointer out of range, then read-direction address
    bus_start();
    send_byte("oor_addr", 8'h80, 1'b1);
    send_byte("oor_ptr", 8'h50, 1'b0);
    send_byte("oor_data", 8'h99, 1'b0);
    bus_stop();
    rd("oor_rd6", 8'h06, 8'hAB);
    rd("oor_rd0", 8'h00, 8'h11);
    rd("rd_oor_addr", 8'h50, 8'h00);
    rd("rd_last", 8'h45, 8'h00);
    bus_start();
    send_byte("rdir_addr", 8'h81, 1'b0);
    send_byte("rdir_b1", 8'h06, 1'b0);
    bus_stop();

    // Read colliding with a DATA write to address 7
    bus_start();
    send_byte("col_addr", 8'h80, 1'b1);
    send_byte("col_ptr", 8'h07, 1'b1);
    ack_q.push_back(1'b1);
    rd_q.push_back(8'h5A);
    @(negedge clk_i);
    byte_i = 8'h5A; byte_valid_i = 1'b1;
    rd_addr_i = 8'h07; rd_req_i = 1'b1;
    @(posedge clk_i); #1;
    check("col_ack", ack_o, ack_q.pop_front());
    check("col_gnt_c1", rd_gnt_o, 0);
    @(negedge clk_i); byte_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("col_gnt_c2", rd_gnt_o, 1);
    check("col_data", rd_data_o, rd_q.pop_front());
    rd_req_i = 1'b0;
    @(posedge clk_i); #1;
    check("col_gnt_pulse", rd_gnt_o, 0);
    bus_stop();

    // MODE1 write, then pointer 0x45 with two data bytes
    bus_start();
    send_byte("m1_addr", 8'h80, 1'b1);
    send_byte("m1_ptr", 8'h00, 1'b1);
    send_byte("m1_data", 8'h31, 1'b1);
    check("m1_mode1", mode1_o, 8'h31);
    bus_start();
    send_byte("wr_addr", 8'h80, 1'b1);
    send_byte("wr_ptr", 8'h45, 1'b1);
    send_byte("wr_d1", 8'h11, 1'b1);
    send_byte("wr_d2", 8'h22, 1'b1);
    bus_stop();
`ifdef I2C_REG_CTRL_AUTOINC_EN
    rd("wr_rd45", 8'h45, 8'h11);
    rd("wr_rd0", 8'h00, 8'h22);
    check("wr_mode1", mode1_o, 8'h22);
`else
    rd("wr_rd45", 8'h45, 8'h22);
    rd("wr_rd0", 8'h00, 8'h31);
    check("wr_mode1", mode1_o, 8'h31);
`endif

    // Non-zero address pins: device {1, 6'h2A} -> 0xD4
    addr_i = 6'h2A;
    bus_start();
    send_byte("pin_addr_old", 8'h80, 1'b0);
    bus_start();
    send_byte("pin_addr", 8'hD4, 1'b1);
    send_byte("pin_ptr", 8'h08, 1'b1);
    send_byte("pin_data", 8'h77, 1'b1);
    bus_stop();
    rd("pin_rd8", 8'h08, 8'h77);
    addr_i = 6'h00;

    // STOP coinciding with a data byte: byte dropped
    bus_start();
    send_byte("cs_addr", 8'h80, 1'b1);
    send_byte("cs_ptr", 8'h09, 1'b1);
    @(negedge clk_i); byte_i = 8'hEE; byte_valid_i = 1'b1; bus_stop_i = 1'b1;
    @(posedge clk_i); #1;
    check("cs_ack", ack_o, 0);
    @(negedge clk_i); byte_valid_i = 1'b0; bus_stop_i = 1'b0;
    rd("cs_rd9", 8'h09, 8'h00);

    // Reset mid-DATA
    bus_start();
    send_byte("rm_addr", 8'h80, 1'b1);
    send_byte("rm_ptr", 8'h0A, 1'b1);
    send_byte("rm_data", 8'h33, 1'b1);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("rm_ack", ack_o, 0);
    check("rm_mode1", mode1_o, 8'h11);
    check("rm_rdata", rd_data_o, 8'h00);
    @(negedge clk_i); rst_i = 1'b0;
    send_byte("rm_idle_byte", 8'h55, 1'b0);
    rd("rm_rdA", 8'h0A, 8'h00);
    rd("rm_rd7", 8'h07, 8'h00);
    rd("rm_rd6", 8'h06, 8'h00);
    rd("rm_rd0", 8'h00, 8'h11);
    bus_start();
    send_byte("rs_addr", 8'h80, 1'b1);
    send_byte("rs_ptr", 8'h0B, 1'b1);
    send_byte("rs_data", 8'h44, 1'b1);
    bus_stop();
    rd("rs_rdB", 8'h0B, 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
